// File: rtl/npc_exec_sequencer.sv
// npc_exec_sequencer: multi-cycle fetch/execute/memory/writeback control FSM
// for the NPC core. Every output is a flop loaded from the next-state decode,
// so no input reaches an output combinationally.
// Optional feature macro: NPC_SEQ_PERF_EN adds the perf_cycles and perf_instret
// counters.
module npc_exec_sequencer #(
    parameter int unsigned INST_W      = 32,
    parameter int unsigned MICRO_LEN   = 10,
    parameter int unsigned TIMEOUT_CYC = 255
) (
    input  logic              clk,
    input  logic              rst,
    output logic              ifu_req_valid,
    input  logic              ifu_req_ready,
    input  logic              ifu_rsp_valid,
    input  logic [INST_W-1:0] ifu_rsp_inst,
    output logic [INST_W-1:0] inst_q,
    input  logic [MICRO_LEN-1:0] micro_cmd,
    input  logic              dec_ebreak,
    output logic              lsu_req_valid,
    input  logic              lsu_req_ready,
    output logic              lsu_we,
    output logic [1:0]        lsu_size,
    input  logic              lsu_rsp_valid,
    output logic              reg_wen,
    output logic              pc_wen,
    output logic              pc_sel,
    output logic              halted,
    output logic              bus_err
`ifdef NPC_SEQ_PERF_EN
    ,
    output logic [63:0]       perf_cycles,
    output logic [63:0]       perf_instret
`endif
);

    localparam int unsigned CNT_W     = 8;
    localparam int unsigned REGEN_BIT = 9;
    localparam int unsigned PCJEN_BIT = 8;
    localparam int unsigned MWEN_HI   = 6;
    localparam int unsigned MWEN_LO   = 5;
    localparam int unsigned MREN_HI   = 4;
    localparam int unsigned MREN_LO   = 3;

    typedef enum logic [2:0] {
        S_FETCH = 3'd0,
        S_IWAIT = 3'd1,
        S_EXEC  = 3'd2,
        S_MEM   = 3'd3,
        S_MWAIT = 3'd4,
        S_WB    = 3'd5,
        S_HALT  = 3'd6
    } state_e;

    state_e               state_q, state_d;
    logic [INST_W-1:0]    inst_d;
    logic [MICRO_LEN-1:0] micro_q, micro_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d, cnt_inc;
    logic                 timeout;
    logic                 is_store_d;
    logic                 is_mem_cmd;

    logic                 ifu_req_valid_q, ifu_req_valid_d;
    logic                 lsu_req_valid_q, lsu_req_valid_d;
    logic                 lsu_we_q, lsu_we_d;
    logic [1:0]           lsu_size_q, lsu_size_d;
    logic                 reg_wen_q, reg_wen_d;
    logic                 pc_wen_q, pc_wen_d;
    logic                 pc_sel_q, pc_sel_d;
    logic                 halted_q, halted_d;
    logic                 bus_err_q, bus_err_d;

    // Next-state, latch and timeout logic; output flops load the decode of the next state.
    always_comb begin
        state_d   = state_q;
        inst_d    = inst_q;
        micro_d   = micro_q;
        bus_err_d = bus_err_q;
        cnt_d     = cnt_q;
        cnt_inc   = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + CNT_W'(1);
        timeout   = (cnt_inc >= CNT_W'(TIMEOUT_CYC));
        is_mem_cmd = (micro_cmd[MWEN_HI:MWEN_LO] != 2'b00) ||
                     (micro_cmd[MREN_HI:MREN_LO] != 2'b00);

        case (state_q)
            S_FETCH: begin
                if (ifu_req_ready) begin
                    state_d = S_IWAIT;
                end else if (timeout) begin
                    state_d   = S_HALT;
                    bus_err_d = 1'b1;
                end
            end
            S_IWAIT: begin
                if (ifu_rsp_valid) begin
                    inst_d  = ifu_rsp_inst;
                    state_d = S_EXEC;
                end else if (timeout) begin
                    state_d   = S_HALT;
                    bus_err_d = 1'b1;
                end
            end
            S_EXEC: begin
                micro_d = micro_cmd;
                if (dec_ebreak) begin
                    state_d = S_HALT;
                end else if (is_mem_cmd) begin
                    state_d = S_MEM;
                end else begin
                    state_d = S_WB;
                end
            end
            S_MEM: begin
                if (lsu_req_ready) begin
                    state_d = S_MWAIT;
                end else if (timeout) begin
                    state_d   = S_HALT;
                    bus_err_d = 1'b1;
                end
            end
            S_MWAIT: begin
                if (lsu_rsp_valid) begin
                    state_d = S_WB;
                end else if (timeout) begin
                    state_d   = S_HALT;
                    bus_err_d = 1'b1;
                end
            end
            S_WB:    state_d = S_FETCH;
            S_HALT:  state_d = S_HALT;
            default: state_d = S_FETCH;
        endcase

        // Counter restarts on any state change and only runs while waiting on a bus.
        if (state_d != state_q) begin
            cnt_d = '0;
        end else if ((state_q == S_FETCH) || (state_q == S_IWAIT) ||
                     (state_q == S_MEM)   || (state_q == S_MWAIT)) begin
            cnt_d = cnt_inc;
        end

        // A store wins over a load when both fields are set.
        is_store_d      = (micro_d[MWEN_HI:MWEN_LO] != 2'b00);
        ifu_req_valid_d = (state_d == S_FETCH);
        lsu_req_valid_d = (state_d == S_MEM);
        lsu_we_d        = (state_d == S_MEM) && is_store_d;
        lsu_size_d      = 2'b00;
        if (state_d == S_MEM) begin
            lsu_size_d = is_store_d ? micro_d[MWEN_HI:MWEN_LO] : micro_d[MREN_HI:MREN_LO];
        end
        reg_wen_d = (state_d == S_WB) && micro_d[REGEN_BIT];
        pc_wen_d  = (state_d == S_WB);
        pc_sel_d  = (state_d == S_WB) && micro_d[PCJEN_BIT];
        halted_d  = (state_d == S_HALT);
    end

    // State, datapath latches and registered outputs; reset value matches the FETCH decode.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= S_FETCH;
            inst_q          <= '0;
            micro_q         <= '0;
            cnt_q           <= '0;
            ifu_req_valid_q <= 1'b1;
            lsu_req_valid_q <= 1'b0;
            lsu_we_q        <= 1'b0;
            lsu_size_q      <= 2'b00;
            reg_wen_q       <= 1'b0;
            pc_wen_q        <= 1'b0;
            pc_sel_q        <= 1'b0;
            halted_q        <= 1'b0;
            bus_err_q       <= 1'b0;
        end else begin
            state_q         <= state_d;
            inst_q          <= inst_d;
            micro_q         <= micro_d;
            cnt_q           <= cnt_d;
            ifu_req_valid_q <= ifu_req_valid_d;
            lsu_req_valid_q <= lsu_req_valid_d;
            lsu_we_q        <= lsu_we_d;
            lsu_size_q      <= lsu_size_d;
            reg_wen_q       <= reg_wen_d;
            pc_wen_q        <= pc_wen_d;
            pc_sel_q        <= pc_sel_d;
            halted_q        <= halted_d;
            bus_err_q       <= bus_err_d;
        end
    end

    assign ifu_req_valid = ifu_req_valid_q;
    assign lsu_req_valid = lsu_req_valid_q;
    assign lsu_we        = lsu_we_q;
    assign lsu_size      = lsu_size_q;
    assign reg_wen       = reg_wen_q;
    assign pc_wen        = pc_wen_q;
    assign pc_sel        = pc_sel_q;
    assign halted        = halted_q;
    assign bus_err       = bus_err_q;

`ifdef NPC_SEQ_PERF_EN
    logic [63:0] perf_cycles_q, perf_cycles_d;
    logic [63:0] perf_instret_q, perf_instret_d;

    // Cycle and retired-instruction counters, frozen once halted.
    always_comb begin
        perf_cycles_d  = perf_cycles_q;
        perf_instret_d = perf_instret_q;
        if (state_q != S_HALT) begin
            perf_cycles_d = perf_cycles_q + 64'd1;
        end
        if (state_q == S_WB) begin
            perf_instret_d = perf_instret_q + 64'd1;
        end
    end

    // Performance counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_cycles_q  <= '0;
            perf_instret_q <= '0;
        end else begin
            perf_cycles_q  <= perf_cycles_d;
            perf_instret_q <= perf_instret_d;
        end
    end

    assign perf_cycles  = perf_cycles_q;
    assign perf_instret = perf_instret_q;
`endif

endmodule

// File: tb/tb_npc_exec_sequencer.sv
// Testbench for npc_exec_sequencer: per-instruction cycle timelines derived
// from phase lengths (fetch wait, response wait, LSU waits) against a
// randomly stalling IFU/LSU, plus directed halt, timeout and reset scenarios.
module tb_npc_exec_sequencer;

    localparam int unsigned TB_TIMEOUT = 4;
    localparam logic [31:0] EBREAK     = 32'h0010_0073;

    logic        clk = 1'b0;
    logic        rst;
    logic        ifu_req_valid, ifu_req_ready, ifu_rsp_valid;
    logic [31:0] ifu_rsp_inst, inst_q;
    logic [9:0]  micro_cmd;
    logic        dec_ebreak;
    logic        lsu_req_valid, lsu_req_ready, lsu_we, lsu_rsp_valid;
    logic [1:0]  lsu_size;
    logic        reg_wen, pc_wen, pc_sel, halted, bus_err;
`ifdef NPC_SEQ_PERF_EN
    logic [63:0] perf_cycles, perf_instret;
`endif

    int errors = 0;
    int checks = 0;

    typedef struct {
        int          df;
        int          di;
        int          dm;
        int          dw;
        logic [31:0] inst;
    } txn_t;

    logic [9:0]  obs_q[$];
    logic [31:0] obs_inst;

    npc_exec_sequencer #(
        .INST_W(32), .MICRO_LEN(10), .TIMEOUT_CYC(TB_TIMEOUT)
    ) dut (
        .clk(clk), .rst(rst),
        .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready),
        .ifu_rsp_valid(ifu_rsp_valid), .ifu_rsp_inst(ifu_rsp_inst),
        .inst_q(inst_q), .micro_cmd(micro_cmd), .dec_ebreak(dec_ebreak),
        .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready),
        .lsu_we(lsu_we), .lsu_size(lsu_size), .lsu_rsp_valid(lsu_rsp_valid),
        .reg_wen(reg_wen), .pc_wen(pc_wen), .pc_sel(pc_sel),
        .halted(halted), .bus_err(bus_err)
`ifdef NPC_SEQ_PERF_EN
        , .perf_cycles(perf_cycles), .perf_instret(perf_instret)
`endif
    );

    always #5 clk = ~clk;

    // Decoder stand-in: the low 10 instruction bits are the micro command.
    always_comb begin
        micro_cmd  = inst_q[9:0];
        dec_ebreak = (inst_q == EBREAK);
    end

    // Output vector: {ifu_req_valid, lsu_req_valid, lsu_we, lsu_size, reg_wen, pc_wen, pc_sel, halted, bus_err}
    function automatic logic [9:0] sample();
        return {ifu_req_valid, lsu_req_valid, lsu_we, lsu_size, reg_wen, pc_wen, pc_sel, halted, bus_err};
    endfunction

    function automatic bit is_mem(txn_t t);
        return (t.inst[6:5] != 2'b00) || (t.inst[4:3] != 2'b00);
    endfunction

    function automatic int txn_len(txn_t t);
        return is_mem(t) ? t.df + t.di + t.dm + t.dw + 6 : t.df + t.di + 4;
    endfunction

    function automatic int wb_cycle(txn_t t);
        return txn_len(t) - 1;
    endfunction

    function automatic bit in_mem_phase(txn_t t, int k);
        int e;
        e = t.df + t.di + 2;
        return is_mem(t) && (k > e) && (k <= e + 1 + t.dm);
    endfunction

    // Expected outputs in cycle k of an instruction's timeline.
    function automatic logic [9:0] exp_vec(txn_t t, int k);
        logic [9:0] v;
        logic [1:0] sz;
        bit         st;
        v  = '0;
        st = (t.inst[6:5] != 2'b00);
        sz = st ? t.inst[6:5] : t.inst[4:3];
        if (k <= t.df) v[9] = 1'b1;
        if (in_mem_phase(t, k)) begin
            v[8]   = 1'b1;
            v[7]   = st;
            v[6:5] = sz;
        end
        if (k == wb_cycle(t)) begin
            v[4] = t.inst[9];
            v[3] = 1'b1;
            v[2] = t.inst[8];
        end
        return v;
    endfunction

    // lsu_we/lsu_size only matter during a request, pc_sel only with pc_wen.
    function automatic logic [9:0] exp_mask(txn_t t, int k);
        logic [9:0] m;
        m = 10'b11_0_00_11_0_11;
        if (in_mem_phase(t, k)) m[7:5] = 3'b111;
        if (k == wb_cycle(t))   m[2]   = 1'b1;
        return m;
    endfunction

    // Plays the IFU/LSU side for one instruction starting in FETCH, recording outputs per cycle.
    task automatic run_txn(input txn_t t);
        int n, i_end, e, m_end, w_end;
        obs_q.delete();
        n     = txn_len(t);
        i_end = t.df + 1 + t.di;
        e     = i_end + 1;
        m_end = e + 1 + t.dm;
        w_end = m_end + 1 + t.dw;
        for (int k = 0; k < n; k++) begin
            obs_q.push_back(sample());
            if (k == e) obs_inst = inst_q;
            ifu_req_ready = 1'b0;
            ifu_rsp_valid = 1'b0;
            ifu_rsp_inst  = $urandom;
            lsu_req_ready = 1'b0;
            lsu_rsp_valid = 1'b0;
            if (k <= t.df) begin
                ifu_req_ready = (k == t.df);
                ifu_rsp_valid = 1'($urandom_range(0, 1));
            end else if (k <= i_end) begin
                if (k == i_end) begin
                    ifu_rsp_valid = 1'b1;
                    ifu_rsp_inst  = t.inst;
                end
            end else if (is_mem(t) && k > e && k <= m_end) begin
                lsu_req_ready = (k == m_end);
                lsu_rsp_valid = 1'($urandom_range(0, 1));
            end else if (is_mem(t) && k > m_end && k <= w_end) begin
                lsu_rsp_valid = (k == w_end);
            end
            @(posedge clk);
            #1;
        end
        ifu_req_ready = 1'b0;
        ifu_rsp_valid = 1'b0;
        lsu_req_ready = 1'b0;
        lsu_rsp_valid = 1'b0;
    endtask

    task automatic idle_inputs();
        ifu_req_ready = 1'b0;
        ifu_rsp_valid = 1'b0;
        ifu_rsp_inst  = '0;
        lsu_req_ready = 1'b0;
        lsu_rsp_valid = 1'b0;
    endtask

    // Reset for two edges, then release; leaves the bench in cycle 1 (FETCH).
    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (sample() !== 10'b10_0000_0000) begin
            errors++;
            $display("FAIL reset_outputs: got %b want %b", sample(), 10'b10_0000_0000);
        end
        checks++;
        if (inst_q !== 32'h0) begin
            errors++;
            $display("FAIL reset_inst_q: got %h want 0", inst_q);
        end
    endtask

    task automatic test_addi();
        txn_t t;
        t = '{df: 0, di: 0, dm: 0, dw: 0, inst: 32'h0050_0201};
        run_txn(t);
        for (int k = 0; k < obs_q.size(); k++) begin
            checks++;
            if ((obs_q[k] & exp_mask(t, k)) !== (exp_vec(t, k) & exp_mask(t, k))) begin
                errors++;
                $display("FAIL addi cyc%0d: got %b want %b", k + 1, obs_q[k], exp_vec(t, k));
            end
        end
        checks++;
        if (obs_inst !== t.inst) begin
            errors++;
            $display("FAIL addi_inst_q: got %h want %h", obs_inst, t.inst);
        end
        checks++;
        if (ifu_req_valid !== 1'b1) begin
            errors++;
            $display("FAIL addi_refetch_cyc5: got %b want 1", ifu_req_valid);
        end
    endtask

    task automatic test_mem();
        txn_t list[3];
        list[0] = '{df: 0, di: 0, dm: 3, dw: 1, inst: 32'h1234_5219};  // LW, micro 1000011001
        list[1] = '{df: 1, di: 2, dm: 0, dw: 2, inst: 32'h0000_0062};  // SW, micro 0001100010
        list[2] = '{df: 0, di: 1, dm: 2, dw: 0, inst: 32'h0000_0230};  // mwen=01 with mren=10
        foreach (list[j]) begin
            run_txn(list[j]);
            for (int k = 0; k < obs_q.size(); k++) begin
                checks++;
                if ((obs_q[k] & exp_mask(list[j], k)) !== (exp_vec(list[j], k) & exp_mask(list[j], k))) begin
                    errors++;
                    $display("FAIL mem%0d cyc%0d: got %b want %b", j, k, obs_q[k], exp_vec(list[j], k));
                end
            end
        end
    endtask

    task automatic test_jal();
        txn_t t;
        t = '{df: 2, di: 0, dm: 0, dw: 0, inst: 32'h0000_6387};
        run_txn(t);
        for (int k = 0; k < obs_q.size(); k++) begin
            checks++;
            if ((obs_q[k] & exp_mask(t, k)) !== (exp_vec(t, k) & exp_mask(t, k))) begin
                errors++;
                $display("FAIL jal cyc%0d: got %b want %b", k, obs_q[k], exp_vec(t, k));
            end
        end
    endtask

    // Back-to-back random instructions with stalls up to the timeout boundary.
    task automatic test_back_to_back();
        txn_t t;
        for (int j = 0; j < 40; j++) begin
            t.df   = int'($urandom_range(0, TB_TIMEOUT - 1));
            t.di   = int'($urandom_range(0, TB_TIMEOUT - 1));
            t.dm   = int'($urandom_range(0, TB_TIMEOUT - 1));
            t.dw   = int'($urandom_range(0, TB_TIMEOUT - 1));
            t.inst = $urandom;
            if (t.inst == EBREAK) t.inst = t.inst ^ 32'h1;
            run_txn(t);
            for (int k = 0; k < obs_q.size(); k++) begin
                checks++;
                if ((obs_q[k] & exp_mask(t, k)) !== (exp_vec(t, k) & exp_mask(t, k))) begin
                    errors++;
                    $display("FAIL rand%0d cyc%0d inst=%h: got %b want %b", j, k, t.inst, obs_q[k], exp_vec(t, k));
                end
            end
            checks++;
            if (obs_inst !== t.inst) begin
                errors++;
                $display("FAIL rand%0d inst_q: got %h want %h", j, obs_inst, t.inst);
            end
        end
    endtask

    task automatic test_ebreak();
        ifu_req_ready = 1'b1;
        @(posedge clk); #1;
        ifu_req_ready = 1'b0;
        ifu_rsp_valid = 1'b1;
        ifu_rsp_inst  = EBREAK;
        @(posedge clk); #1;
        idle_inputs();
        checks++;
        if (sample() !== 10'b0) begin
            errors++;
            $display("FAIL ebreak_exec: got %b want %b", sample(), 10'b0);
        end
        @(posedge clk); #1;
        for (int c = 0; c < 20; c++) begin
            checks++;
            if (sample() !== 10'b00_0000_0010) begin
                errors++;
                $display("FAIL ebreak_halt cyc%0d: got %b want %b", c, sample(), 10'b00_0000_0010);
            end
            ifu_req_ready = 1'($urandom_range(0, 1));
            ifu_rsp_valid = 1'($urandom_range(0, 1));
            lsu_req_ready = 1'($urandom_range(0, 1));
            lsu_rsp_valid = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
        end
        idle_inputs();
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        checks++;
        if (sample() !== 10'b10_0000_0000 || inst_q !== 32'h0) begin
            errors++;
            $display("FAIL ebreak_rst: got %b inst=%h want %b inst=0", sample(), inst_q, 10'b10_0000_0000);
        end
    endtask

    // Response never arrives: halt with bus_err after TB_TIMEOUT cycles in IWAIT.
    task automatic test_timeout_iwait();
        ifu_req_ready = 1'b1;
        @(posedge clk); #1;
        ifu_req_ready = 1'b0;
        for (int c = 1; c <= TB_TIMEOUT; c++) begin
            checks++;
            if (sample() !== 10'b0) begin
                errors++;
                $display("FAIL tmo_iwait wait%0d: got %b want %b", c, sample(), 10'b0);
            end
            @(posedge clk); #1;
        end
        for (int c = 0; c < 3; c++) begin
            checks++;
            if (sample() !== 10'b00_0000_0011) begin
                errors++;
                $display("FAIL tmo_iwait halt%0d: got %b want %b", c, sample(), 10'b00_0000_0011);
            end
            @(posedge clk); #1;
        end
        do_reset();
    endtask

    // IFU never accepts: halt with bus_err after TB_TIMEOUT cycles in FETCH.
    task automatic test_timeout_fetch();
        for (int c = 1; c <= TB_TIMEOUT; c++) begin
            checks++;
            if (sample() !== 10'b10_0000_0000) begin
                errors++;
                $display("FAIL tmo_fetch wait%0d: got %b want %b", c, sample(), 10'b10_0000_0000);
            end
            @(posedge clk); #1;
        end
        checks++;
        if (sample() !== 10'b00_0000_0011) begin
            errors++;
            $display("FAIL tmo_fetch halt: got %b want %b", sample(), 10'b00_0000_0011);
        end
        do_reset();
    endtask

    // Reset just before the limit: counter cleared, pending response dropped, no error.
    task automatic test_reset_mid_iwait();
        txn_t t;
        ifu_req_ready = 1'b1;
        @(posedge clk); #1;
        ifu_req_ready = 1'b0;
        repeat (TB_TIMEOUT - 1) begin
            @(posedge clk); #1;
        end
        rst           = 1'b1;
        ifu_rsp_valid = 1'b1;
        ifu_rsp_inst  = 32'hDEAD_BEEF;
        @(posedge clk); #1;
        rst = 1'b0;
        idle_inputs();
        checks++;
        if (sample() !== 10'b10_0000_0000 || inst_q !== 32'h0) begin
            errors++;
            $display("FAIL rst_iwait: got %b inst=%h want %b inst=0", sample(), inst_q, 10'b10_0000_0000);
        end
        t = '{df: TB_TIMEOUT - 1, di: TB_TIMEOUT - 1, dm: 0, dw: 0, inst: 32'h0000_0201};
        run_txn(t);
        for (int k = 0; k < obs_q.size(); k++) begin
            checks++;
            if ((obs_q[k] & exp_mask(t, k)) !== (exp_vec(t, k) & exp_mask(t, k))) begin
                errors++;
                $display("FAIL rst_iwait_next cyc%0d: got %b want %b", k, obs_q[k], exp_vec(t, k));
            end
        end
    endtask

    initial begin
        idle_inputs();
        rst = 1'b1;
        test_reset();
        test_addi();
        test_mem();
        test_jal();
        test_back_to_back();
        test_ebreak();
        test_timeout_iwait();
        test_timeout_fetch();
        test_reset_mid_iwait();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/npc_exec_sequencer.md
Name: npc_exec_sequencer

Overview:
- Multi-cycle control FSM for the NPC core.
- Fetches an instruction over a valid/ready IFU handshake and latches it in inst_q, which drives the decode lookup table combinationally.
- Consumes the 10-bit micro command from the decoder and sequences the load/store unit handshake, register-file write, and PC update.
- Halts on EBREAK or on a bus timeout.

Parameters:
- INST_W, 32, instruction width.
- MICRO_LEN, 10, micro command width: regen[9], pcjen[8], pcren[7], mwen[6:5], mren[4:3], imm_type[2:0].
- TIMEOUT_CYC, 255, maximum cycles waiting on any response before bus error; range 1..255.

Ports:
- clk  in  1  core clock.
- rst  in  1  synchronous, active-high reset.
- ifu_req_valid  out  1  fetch request.
- ifu_req_ready  in  1  IFU accepts request.
- ifu_rsp_valid  in  1  fetched instruction valid.
- ifu_rsp_inst  in  INST_W  fetched instruction.
- inst_q  out  INST_W  latched instruction, feeds decoder/immgen.
- micro_cmd  in  MICRO_LEN  decoder output for inst_q.
- dec_ebreak  in  1  decoder flags EBREAK.
- lsu_req_valid  out  1  memory request.
- lsu_req_ready  in  1  LSU accepts request.
- lsu_we  out  1  1 = store, 0 = load.
- lsu_size  out  2  mwen or mren field of the latched micro command.
- lsu_rsp_valid  in  1  load data / store ack.
- reg_wen  out  1  register-file write strobe.
- pc_wen  out  1  PC update strobe.
- pc_sel  out  1  1 = jump target, 0 = pc+4.
- halted  out  1  core stopped.
- bus_err  out  1  timeout occurred, sticky.

Behaviour:
- States: FETCH, IWAIT, EXEC, MEM, MWAIT, WB, HALT. Reset state is FETCH.
- Reset values: inst_q = 0, micro_q = 0, timeout counter = 0, halted = 0, bus_err = 0, all strobes 0.
- All outputs are decoded from registered state and registered micro_q. No combinational path from any input to any output.
- FETCH:
  - ifu_req_valid = 1.
  - ifu_req_ready = 1 -> IWAIT.
- IWAIT:
  - ifu_rsp_valid = 1 -> inst_q <= ifu_rsp_inst, go to EXEC.
  - ifu_rsp_valid arriving in the same cycle as the request handshake is ignored; the response is accepted in IWAIT only.
- EXEC (1 cycle):
  - micro_q <= micro_cmd.
  - dec_ebreak = 1 -> HALT, overriding micro_cmd.
  - Else mren != 0 or mwen != 0 -> MEM.
  - Else -> WB.
  - mren and mwen both nonzero: treated as a store (mwen wins).
- MEM:
  - lsu_req_valid = 1; lsu_we = (micro_q.mwen != 0); lsu_size = mwen if store, else mren.
  - Signals are held stable until lsu_req_ready; then -> MWAIT.
- MWAIT:
  - lsu_rsp_valid -> WB.
  - Stores also wait for their ack.
- WB (1 cycle):
  - reg_wen = micro_q.regen; pc_wen = 1; pc_sel = micro_q.pcjen.
  - Then -> FETCH.
- HALT:
  - halted = 1; all strobes and request valids are 0.
  - Left only by rst.
- Timeout:
  - Counter resets to 0 on every state change.
  - Increments each cycle spent in FETCH, IWAIT, MEM or MWAIT, saturating at 255.
  - Counter reaching TIMEOUT_CYC -> bus_err <= 1, next state HALT.
  - A handshake completing in the same cycle as the timeout wins: normal transition, no error.
- Latency:
  - Non-memory instruction with zero-wait IFU: 4 cycles (FETCH, IWAIT, EXEC, WB).
  - Memory instruction with zero-wait LSU: 6 cycles.
- rst asserted mid-operation: next cycle is FETCH with all registers at reset values. A pending IFU/LSU response is dropped; bus agents are reset by the same rst.

Optional Feature:
- Macro: NPC_SEQ_PERF_EN.
- Defined:
  - Adds output perf_cycles[63:0], +1 every cycle when not halted.
  - Adds output perf_instret[63:0], +1 in each WB cycle.
  - Both are 0 on rst, wrap modulo 2^64, and freeze in HALT.
- Undefined: neither port nor its counters exist.

Test Plan:
- Zero-wait ADDI (micro 10'b1000000001): reg_wen = 1 and pc_wen = 1, pc_sel = 0, in cycle 4 after leaving reset; ifu_req_valid again in cycle 5.
- LW (micro 10'b1000011001) with lsu_req_ready delayed 3 cycles: lsu_we = 0 and lsu_size = 2'b11 held stable throughout; reg_wen exactly one cycle after lsu_rsp_valid.
- SW (micro 10'b0001100010): lsu_we = 1, lsu_size = 2'b11; WB with reg_wen = 0, pc_wen = 1.
- JAL (micro 10'b1110000111): WB cycle has reg_wen = 1, pc_wen = 1, pc_sel = 1.
- dec_ebreak = 1 in EXEC: halted = 1 the next cycle; no further ifu_req_valid over 20 cycles; rst returns to FETCH with halted = 0.
- TIMEOUT_CYC = 4, ifu_rsp_valid never asserted: bus_err = 1 and halted = 1 after 4 cycles in IWAIT; asserting rst mid-IWAIT before the limit clears the counter and produces no error.
